seq_mult_ctrl: RTL and testbench

SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

---
 rtl/seq_mult_pkg.sv | 20 ++
 rtl/mult_step_counter.sv | 23 ++
 rtl/seq_mult_ctrl.sv | 107 ++++++++++
 tb/tb_seq_mult_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and sizing for the sequential shift-and-add multiplier controller.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int MULT_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;

  function automatic int step_w(input int mult_w);
    return $clog2(mult_w + 1);
  endfunction

  localparam int STEP_W = step_w(MULT_W_DEF);

endpackage

// File: rtl/mult_step_counter.sv
// Accumulate-step counter: cleared on an accepted start, bumped once per ACCUM cycle.
module mult_step_counter #(
  parameter int MAX = 8,
  parameter int W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst)      count <= '0;
    else if (clr)  count <= '0;
    else if (inc)  count <= count + 1'b1;
  end

  assign last = (count == W'(MAX - 1));

endmodule

// File: rtl/seq_mult_ctrl.sv
// Shift-and-add multiplier controller driving an external left shifter.
// Optional early exit on an exhausted multiplier: define SEQ_MULT_EARLY_EXIT_EN.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int MULT_W = MULT_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MULT_W-1:0] multiplier,
  input  logic [ACC_W-1:0]  shift_in,
  output logic              shift_start,
  output logic              shift_enb,
  output logic [ACC_W-1:0]  product,
  output logic              done,
  output logic              busy,
  output logic              ovf
);

  localparam int SW = step_w(MULT_W);

  state_t            state, state_nx;
  logic [MULT_W-1:0] mreg, mreg_nx;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    sum;
  logic              ovf_q, done_q;
  logic              accept, last, exit_acc, exit_load;

  assign mreg_nx = mreg >> 1;
  assign sum     = {1'b0, acc} + {1'b0, shift_in};

`ifdef SEQ_MULT_EARLY_EXIT_EN
  assign exit_acc  = last || (mreg_nx == '0);
  assign exit_load = (mreg == '0);
`else
  assign exit_acc  = last;
  assign exit_load = 1'b0;
`endif

  mult_step_counter #(.MAX(MULT_W), .W(SW)) u_step (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (state == S_ACCUM),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = exit_load ? S_DONE : S_ACCUM;
      S_ACCUM: if (exit_acc) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Controls are masked while rst is low so nothing leaks out during reset.
  always_comb begin
    accept      = 1'b0;
    shift_start = 1'b0;
    shift_enb   = 1'b0;
    busy        = 1'b0;
    if (rst) begin
      accept      = (state == S_IDLE) && start;
      shift_start = accept;
      shift_enb   = (state == S_ACCUM) && !exit_acc;
      busy        = (state != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mreg    <= '0;
      acc     <= '0;
      ovf_q   <= 1'b0;
      product <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == S_DONE);
      if (accept) begin
        mreg  <= multiplier;
        acc   <= '0;
        ovf_q <= 1'b0;
      end else if (state == S_ACCUM) begin
        if (mreg[0]) begin
          acc <= sum[ACC_W-1:0];
          if (sum[ACC_W]) ovf_q <= 1'b1;
        end
        mreg <= mreg_nx;
      end
      if (state == S_DONE) product <= acc;
    end
  end

  assign done = done_q & rst;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Randomized self-checking bench for seq_mult_ctrl with an ideal left-shifter model.
module tb_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  multiplier = '0;
  logic [15:0] shift_in;
  logic        shift_start, shift_enb, done, busy, ovf;
  logic [15:0] product;

  logic [15:0] mcand = '0;
  logic [15:0] sh = '0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          excl_bad = 0;

  always #5 clk = ~clk;

  seq_mult_ctrl #(.MULT_W(8), .ACC_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .multiplier  (multiplier),
    .shift_in    (shift_in),
    .shift_start (shift_start),
    .shift_enb   (shift_enb),
    .product     (product),
    .done        (done),
    .busy        (busy),
    .ovf         (ovf)
  );

  always @(posedge clk) begin
    if (shift_start)    sh <= mcand;
    else if (shift_enb) sh <= sh << 1;
  end
  assign shift_in = sh;

  always @(negedge clk)
    if (shift_start && shift_enb) excl_bad <= excl_bad + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Sum of the 16-bit-truncated shifted multiplicands selected by multiplier bits.
  function automatic longint raw_sum(input logic [15:0] mc, input logic [7:0] mu);
    longint s = 0;
    for (int k = 0; k < 8; k++)
      if (mu[k]) s += (longint'(mc) << k) & 64'hFFFF;
    return s;
  endfunction

  // Cycles from the start cycle to the cycle in which done is seen.
  function automatic int exp_lat(input logic [7:0] mu);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    if (mu == 0) return 3;
    return $clog2(int'(mu) + 1) + 3;
`else
    return 11;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [15:0] mc, input logic [7:0] mu,
                        input int inj_start, input int inj_rst);
    longint     s;
    int         cyc;
    bit         got;
    logic [15:0] prev;
    s = raw_sum(mc, mu);
    @(negedge clk);
    mcand = mc; multiplier = mu; start = 1'b1; prev = product;
    @(negedge clk);
    start = 1'b0; cyc = 1; got = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_hold"}, product, prev);
    while (cyc < 40 && !got) begin
      if (done) got = 1'b1;
      else begin
        start = (cyc == inj_start);
        if (cyc == inj_start) multiplier = 8'd3;
        rst = !(cyc == inj_rst);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; rst = 1'b1;
    if (inj_rst > 0) begin
      chk({tag, "_nodone"}, got, 0);
      chk({tag, "_prod0"}, product, 0);
      chk({tag, "_idle"}, busy, 0);
    end else begin
      chk({tag, "_done"}, got, 1);
      chk({tag, "_lat"}, cyc, exp_lat(mu));
      chk({tag, "_prod"}, product, s & 64'hFFFF);
      chk({tag, "_ovf"}, ovf, (s >= 65536) ? 1 : 0);
      @(negedge clk);
      chk({tag, "_pulse"}, done, 0);
      chk({tag, "_after"}, busy, 0);
      chk({tag, "_stable"}, product, s & 64'hFFFF);
    end
  endtask

  initial begin
    start = 1'b1;
    multiplier = 8'd7;
    repeat (3) @(negedge clk);
    chk("rst_prod", product, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sst", shift_start, 0);
    chk("rst_senb", shift_enb, 0);
    chk("rst_ovf", ovf, 0);
    start = 1'b0;
    rst = 1'b1;

    run_op("m127x5", 16'd127, 8'd5, -1, -1);
    run_op("m255x255", 16'd255, 8'd255, -1, -1);
    run_op("m300x255", 16'd300, 8'd255, -1, -1);
    run_op("mx0", 16'd1234, 8'd0, -1, -1);
    run_op("ign_acc", 16'd127, 8'd5, 4, -1);
    run_op("ign_done", 16'd99, 8'd200, exp_lat(8'd200) - 1, -1);
    run_op("top_bit", 16'hFFFF, 8'h80, -1, -1);
    run_op("mid_rst", 16'd127, 8'd5, -1, 5);
    chk("post_rst_ovf", ovf, 0);

    for (int i = 0; i < 24; i++)
      run_op($sformatf("rnd%0d", i), 16'($urandom), 8'($urandom), -1, -1);

    chk("excl", excl_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
